// File: rtl/clock_enable_manager.sv
// Per-channel divided clock enables with square-wave levels, wrap-aligned divisor reload,
// and a watchdog that pulses the DCM reset when lock is lost for too long.
module clock_enable_manager #(
   parameter int  CHANNELS    = 4,
   parameter int  CNT_WIDTH   = 8,
   parameter int  DEFAULT_DIV = 5,
   parameter int  WD_TIMEOUT  = 50000,
   parameter int  WD_PULSE    = 10,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 input_clk,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  channel_enable,
   input  logic                 resync,
   input  logic                 div_valid,
   input  logic [CH_W-1:0]      div_ch,
   input  logic [CNT_WIDTH-1:0] div_value,
   output logic                 div_ready,
   input  logic                 dcm_locked_in,
   output logic [CHANNELS-1:0]  clk_en_out,
   output logic [CHANNELS-1:0]  clk_level_out,
   output logic                 dcm_reset_out,
   output logic [7:0]           wd_trips
);

   localparam int TMR_W = $clog2(WD_TIMEOUT + 1);
   localparam int PLS_W = (WD_PULSE > 1) ? $clog2(WD_PULSE) : 1;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(WD_TIMEOUT - 1);
   localparam logic [PLS_W-1:0]     PLS_ONE   = PLS_W'(1);
   localparam logic [PLS_W-1:0]     PLS_LAST  = PLS_W'(WD_PULSE - 1);

   typedef enum logic [1:0] {ST_LOCKED, ST_COUNTING, ST_PULSE} wd_state_t;

   logic [CNT_WIDTH-1:0] cnt      [CHANNELS];
   logic [CNT_WIDTH-1:0] div_reg  [CHANNELS];
   logic [CNT_WIDTH-1:0] last_cnt [CHANNELS];
   logic [CHANNELS-1:0]  wrap;

   logic                 pend_valid;
   logic [CH_W-1:0]      pend_ch;
   logic [CNT_WIDTH-1:0] pend_val;
   logic                 pend_in_range;
   logic                 pend_apply;

   wd_state_t            wd_state;
   logic [TMR_W-1:0]     timer;
   logic [PLS_W-1:0]     pulse_cnt;

   assign div_ready     = ~pend_valid;
   assign pend_in_range = 32'(pend_ch) < CHANNELS;

   // A divisor of 0 behaves as 1, so its last count is 0 as well.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         last_cnt[i] = (div_reg[i] == '0) ? '0 : div_reg[i] - CNT_ONE;
         wrap[i]     = channel_enable[i] && !resync && (cnt[i] == last_cnt[i]);
      end
   end

   always_comb begin
      // NOTE: default assignment first, so no path through this block leaves pend_apply unassigned (no latch).
      pend_apply = 1'b0;
      if (pend_valid)
         pend_apply = !pend_in_range || resync || !channel_enable[pend_ch] || wrap[pend_ch];
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge input_clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]     <= '0;
            // NOTE: the divisor array must be reset, since reset restores DEFAULT_DIV on every channel.
            div_reg[i] <= CNT_WIDTH'(DEFAULT_DIV);
         end
         clk_en_out    <= '0;
         clk_level_out <= '0;
         pend_valid    <= 1'b0;
         pend_ch       <= '0;
         pend_val      <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!channel_enable[i] || resync) begin
               cnt[i]           <= '0;
               clk_en_out[i]    <= 1'b0;
               clk_level_out[i] <= 1'b0;
            end else begin
               cnt[i]           <= wrap[i] ? '0 : cnt[i] + CNT_ONE;
               clk_en_out[i]    <= wrap[i];
               clk_level_out[i] <= clk_level_out[i] ^ clk_en_out[i];
            end
         end
         // Pending divisor lands only at a period boundary; the slot frees the following cycle.
         if (pend_apply) begin
            pend_valid <= 1'b0;
            if (pend_in_range)
               div_reg[pend_ch] <= pend_val;
         end else if (div_valid && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_ch    <= div_ch;
            pend_val   <= div_value;
         end
      end
   end

   always_ff @(posedge input_clk) begin
      if (reset) begin
         wd_state      <= ST_LOCKED;
         timer         <= '0;
         pulse_cnt     <= '0;
         dcm_reset_out <= 1'b0;
         wd_trips      <= '0;
      end else begin
         case (wd_state)
            ST_LOCKED: begin
               if (!dcm_locked_in)
                  wd_state <= ST_COUNTING;
            end
            ST_COUNTING: begin
               if (dcm_locked_in) begin
                  wd_state <= ST_LOCKED;
                  timer    <= '0;
               end else begin
                  timer <= timer + TMR_ONE;
                  if (timer == TMR_LAST) begin
                     wd_state      <= ST_PULSE;
                     pulse_cnt     <= '0;
                     dcm_reset_out <= 1'b1;
                     if (wd_trips != 8'hFF)
                        wd_trips <= wd_trips + 8'd1;
                  end
               end
            end
            ST_PULSE: begin
               if (pulse_cnt == PLS_LAST) begin
                  wd_state      <= ST_COUNTING;
                  timer         <= '0;
                  dcm_reset_out <= 1'b0;
               end else begin
                  pulse_cnt <= pulse_cnt + PLS_ONE;
               end
            end
            default: wd_state <= ST_LOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_enable_manager.sv
// Bench for clock_enable_manager: directed scenarios with literal expectations, then random
// stimulus compared every cycle against an epoch-based arithmetic model.
module tb_clock_enable_manager;

   localparam int CH   = 4;
   localparam int CW   = 8;
   localparam int DDIV = 5;
   localparam int WDT  = 20;
   localparam int WDP  = 3;

   logic          input_clk = 1'b0;
   logic          reset;
   logic [CH-1:0] channel_enable;
   logic          resync;
   logic          div_valid;
   logic [1:0]    div_ch;
   logic [CW-1:0] div_value;
   logic          div_ready;
   logic          dcm_locked_in;
   logic [CH-1:0] clk_en_out;
   logic [CH-1:0] clk_level_out;
   logic          dcm_reset_out;
   logic [7:0]    wd_trips;

   clock_enable_manager #(
      .CHANNELS(CH), .CNT_WIDTH(CW), .DEFAULT_DIV(DDIV), .WD_TIMEOUT(WDT), .WD_PULSE(WDP)
   ) dut (
      .input_clk(input_clk), .reset(reset), .channel_enable(channel_enable), .resync(resync),
      .div_valid(div_valid), .div_ch(div_ch), .div_value(div_value), .div_ready(div_ready),
      .dcm_locked_in(dcm_locked_in), .clk_en_out(clk_en_out), .clk_level_out(clk_level_out),
      .dcm_reset_out(dcm_reset_out), .wd_trips(wd_trips)
   );

   always #5 input_clk = ~input_clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: each running channel has an epoch (start edge, level parity at start, divisor).
   int            m_div    [CH];
   bit            m_active [CH];
   int            m_start  [CH];
   bit            m_base   [CH];
   logic [CH-1:0] m_strobe;
   logic [CH-1:0] m_level;
   bit            m_pend;
   int            m_pch;
   int            m_pval;
   bit            m_counting;
   int            m_streak;
   int            m_pulse_left;
   int            m_trips;
   int            n       = 0;
   bit            m_valid = 0;

   task automatic model_step();
      bit pend_before;
      int deff;
      n++;
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            m_div[i] = DDIV; m_active[i] = 0; m_start[i] = 0; m_base[i] = 0;
         end
         m_strobe = '0; m_level = '0; m_pend = 0;
         m_counting = 0; m_streak = 0; m_pulse_left = 0; m_trips = 0;
         m_valid = 1;
         return;
      end
      pend_before = m_pend;
      for (int i = 0; i < CH; i++) begin
         deff = (m_div[i] == 0) ? 1 : m_div[i];
         if (!channel_enable[i] || resync) begin
            m_active[i] = 0; m_strobe[i] = 1'b0; m_level[i] = 1'b0;
         end else begin
            if (!m_active[i]) begin
               m_active[i] = 1; m_start[i] = n; m_base[i] = 0;
            end
            m_strobe[i] = ((n - m_start[i] + 1) % deff) == 0;
            m_level[i]  = m_base[i] ^ ((((n - m_start[i]) / deff) % 2) == 1);
         end
      end
      if (pend_before) begin
         if (resync || !channel_enable[m_pch] || m_strobe[m_pch]) begin
            m_div[m_pch] = m_pval;
            m_pend = 0;
            if (m_strobe[m_pch]) begin
               m_start[m_pch] = n + 1;
               m_base[m_pch]  = !m_level[m_pch];
            end
         end
      end else if (div_valid) begin
         m_pend = 1; m_pch = int'(div_ch); m_pval = int'(div_value);
      end
      if (m_pulse_left > 0) begin
         m_pulse_left--;
         if (m_pulse_left == 0) begin
            m_counting = 1; m_streak = 0;
         end
      end else if (!m_counting) begin
         if (!dcm_locked_in) begin
            m_counting = 1; m_streak = 0;
         end
      end else if (dcm_locked_in) begin
         m_counting = 0; m_streak = 0;
      end else begin
         m_streak++;
         if (m_streak == WDT) begin
            m_pulse_left = WDP;
            if (m_trips < 255) m_trips++;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge input_clk);
         model_step();
         #1;
         if (m_valid) begin
            check("clk_en_out",    32'(clk_en_out),    32'(m_strobe));
            check("clk_level_out", 32'(clk_level_out), 32'(m_level));
            check("div_ready",     32'(div_ready),     32'(!m_pend));
            check("dcm_reset_out", 32'(dcm_reset_out), 32'(m_pulse_left > 0));
            check("wd_trips",      32'(wd_trips),      32'(m_trips));
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge input_clk);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (div_ready !== 1'b1 && guard < 64) begin
         step(1);
         guard++;
      end
      check("div_ready_wait", 32'(div_ready), 32'd1);
   endtask

   task automatic load(input int ch, input int val);
      wait_ready();
      div_valid = 1'b1; div_ch = 2'(ch); div_value = 8'(val);
      step(1);
      div_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; channel_enable = '0; resync = 1'b0; div_valid = 1'b0;
      div_ch = '0; div_value = '0; dcm_locked_in = 1'b1;
      step(3);
      reset = 1'b0;
      check("rst_en",    32'(clk_en_out),    32'd0);
      check("rst_level", 32'(clk_level_out), 32'd0);
      check("rst_ready", 32'(div_ready),     32'd1);
      check("rst_trips", 32'(wd_trips),      32'd0);

      // ch0 at the default divisor: first strobe on the 5th enabled edge, level period 10.
      channel_enable = 4'b0001;
      step(4); check("ch0_pre_strobe", 32'(clk_en_out[0]), 32'd0);
      step(1); check("ch0_strobe1",    32'(clk_en_out[0]), 32'd1);
      step(1); check("ch0_level_up",   32'(clk_level_out[0]), 32'd1);
      step(4); check("ch0_strobe2",    32'(clk_en_out[0]), 32'd1);
      step(1); check("ch0_level_down", 32'(clk_level_out[0]), 32'd0);

      // Reload ch1 to 3 at count 1: old period finishes, then period 3.
      channel_enable = 4'b0011;
      step(1);
      div_valid = 1'b1; div_ch = 2'd1; div_value = 8'd3;
      step(1);
      div_valid = 1'b0;
      check("ld_ready_low", 32'(div_ready), 32'd0);
      step(2); check("ld_ready_hold", 32'(div_ready), 32'd0);
      step(1); check("ld_old_wrap",   32'(clk_en_out[1]), 32'd1);
      check("ld_ready_back", 32'(div_ready), 32'd1);
      step(2); check("ld_new_gap",    32'(clk_en_out[1]), 32'd0);
      step(1); check("ld_new_strobe", 32'(clk_en_out[1]), 32'd1);

      // Divisors 2,3,4,6 with resync: pattern repeats every 12 cycles.
      channel_enable = '0;
      step(1);
      load(0, 2); load(1, 3); load(2, 4); load(3, 6);
      step(2);
      channel_enable = 4'hF;
      step(7);
      resync = 1'b1;
      step(1);
      resync = 1'b0;
      check("rs_en_clear",    32'(clk_en_out),    32'd0);
      check("rs_level_clear", 32'(clk_level_out), 32'd0);
      step(6);  check("rs_mid",     32'(clk_en_out), 32'hB);
      step(6);  check("rs_common1", 32'(clk_en_out), 32'hF);
      step(12); check("rs_common2", 32'(clk_en_out), 32'hF);

      // Divisor 0 on ch2 behaves as 1.
      load(2, 0);
      wait_ready();
      step(1);
      for (int k = 0; k < 4; k++) begin
         check("d0_strobe", 32'(clk_en_out[2]), 32'd1);
         step(1);
      end

      // Watchdog: trip after 20 unlocked counting cycles, 3-cycle pulse, retrip 20 later.
      dcm_locked_in = 1'b0;
      step(20); check("wd_before_trip", 32'(dcm_reset_out), 32'd0);
      step(1);  check("wd_pulse_on",    32'(dcm_reset_out), 32'd1);
      check("wd_trips1", 32'(wd_trips), 32'd1);
      step(2);  check("wd_pulse_last",  32'(dcm_reset_out), 32'd1);
      step(1);  check("wd_pulse_off",   32'(dcm_reset_out), 32'd0);
      step(19); check("wd_before_2nd",  32'(dcm_reset_out), 32'd0);
      step(1);  check("wd_pulse2_on",   32'(dcm_reset_out), 32'd1);
      check("wd_trips2", 32'(wd_trips), 32'd2);

      // Reset in the middle of a pulse.
      step(1);
      reset = 1'b1;
      step(1);
      check("midrst_dcm",   32'(dcm_reset_out), 32'd0);
      check("midrst_trips", 32'(wd_trips),      32'd0);
      check("midrst_en",    32'(clk_en_out),    32'd0);
      check("midrst_level", 32'(clk_level_out), 32'd0);
      check("midrst_ready", 32'(div_ready),     32'd1);
      reset = 1'b0; dcm_locked_in = 1'b1;

      for (int c = 0; c < 2000; c++) begin
         reset  = ($urandom_range(0, 399) == 0);
         resync = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 31) == 0) channel_enable[i] = ~channel_enable[i];
         div_valid = ($urandom_range(0, 3) == 0);
         div_ch    = 2'($urandom_range(0, 3));
         div_value = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) dcm_locked_in = ~dcm_locked_in;
         step(1);
      end
      reset = 1'b0; resync = 1'b0; div_valid = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clock_enable_manager.md
CLOCK_ENABLE_MANAGER -- requirements
Module: clock_enable_manager

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divided-enable channels (1-16).
REQ-002 Parameter CNT_WIDTH, default 8: divisor and per-channel counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 5: divisor loaded into every channel on reset.
REQ-004 Parameter WD_TIMEOUT, default 50000: consecutive unlocked cycles before the watchdog trips.
REQ-005 Parameter WD_PULSE, default 10: length in cycles of the DCM reset pulse.
REQ-006 input_clk  in  1: sole clock; all logic on its rising edge.
REQ-007 reset  in  1: reset, synchronous and active-high.
REQ-008 channel_enable  in  CHANNELS: per-channel run enable.
REQ-009 resync  in  1: single-cycle request to phase-align all channels.
REQ-010 div_valid  in  1: divisor load request.
REQ-011 div_ch  in  clog2(CHANNELS) (min 1): target channel of the load.
REQ-012 div_value  in  CNT_WIDTH: new divisor.
REQ-013 div_ready  out  1: load slot free; a load is accepted when div_valid and div_ready are both high.
REQ-014 dcm_locked_in  in  1: lock status from the DCM, already synchronous to input_clk.
REQ-015 clk_en_out  out  CHANNELS: one-cycle enable strobe per channel.
REQ-016 clk_level_out  out  CHANNELS: 50%-duty square wave per channel, toggling on each strobe.
REQ-017 dcm_reset_out  out  1: active-high reset request to the DCM.
REQ-018 wd_trips  out  8: saturating count of watchdog trips.

Function
REQ-019 Divisor D is effective as max(D,1); value 0 SHALL behave as 1.
REQ-020 An enabled channel's counter SHALL count 0..D-1; at count D-1 it returns to 0 and asserts its clk_en_out bit for exactly that cycle (registered output).
REQ-021 clk_level_out[i] SHALL toggle on the cycle following each strobe of channel i; level period = 2*D cycles.
REQ-022 A disabled channel SHALL hold its counter at 0 and its strobe at 0, and SHALL drive level 0.
REQ-023 On enable rising, the first strobe SHALL appear D cycles after the first cycle enable is sampled high.
REQ-024 resync high SHALL clear every counter and level to 0 on the next edge; strobes are suppressed that cycle.
REQ-025 Divisor load: one pending register; div_ready = not pending.
REQ-026 A pending load SHALL apply to its channel only on that channel's wrap cycle (count D-1 -> 0), so no partial period is emitted.
REQ-027 A pending load for a disabled channel, or one coinciding with resync, SHALL apply on the next edge.
REQ-028 div_ready SHALL return high the cycle after the pending load applies; a new load cannot be accepted in the apply cycle.
REQ-029 Watchdog FSM states: LOCKED, COUNTING, PULSE.
REQ-030 LOCKED -> COUNTING when dcm_locked_in is 0; the timer increments each cycle while in COUNTING and dcm_locked_in is 0.
REQ-031 COUNTING -> LOCKED with timer cleared whenever dcm_locked_in is 1.
REQ-032 COUNTING -> PULSE when the timer reaches WD_TIMEOUT; wd_trips increments, saturating at 255.
REQ-033 PULSE SHALL drive dcm_reset_out high for exactly WD_PULSE cycles, ignoring dcm_locked_in, then clear the timer and enter COUNTING.
REQ-034 The timer SHALL be sized to hold WD_TIMEOUT without wrap.

Reset
REQ-035 reset high SHALL, on the next edge: clear counters, clk_en_out=0, clk_level_out=0, divisors=DEFAULT_DIV, clear pending (div_ready=1), FSM=LOCKED, timer=0, dcm_reset_out=0, wd_trips=0.
REQ-036 reset SHALL override resync, loads, and a PULSE in progress (pulse truncated).

Verification
REQ-037 reset, then enable ch0 with D=5 -> ch0 strobes every 5 cycles, first strobe at cycle 5, level period 10.
REQ-038 Load ch1 D=3 while ch1 runs D=5 at count 1 -> div_ready low; old period completes (strobe at count 4), then period 3; div_ready high the following cycle.
REQ-039 Enable all 4 channels with D=2,3,4,6, pulse resync -> all counters 0; common strobe every 12 cycles thereafter.
REQ-040 D=0 on ch2 -> strobe every cycle; level toggles every cycle.
REQ-041 Hold dcm_locked_in=0 with WD_TIMEOUT=20 and WD_PULSE=3 -> dcm_reset_out high for 3 cycles after 20 unlocked cycles, wd_trips=1; lock held low -> second trip 20 cycles later.
REQ-042 Assert reset mid-PULSE -> dcm_reset_out=0, wd_trips=0, and all outputs at their reset values on the next edge.
